// File: rtl/dyn_mix_sequencer.sv
// Frame sequencer: kicks dynamics_calc once per sample tick, latches its eight
// voice outputs, accumulates the enabled voices and emits one saturated mix sample.
module dyn_mix_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned MIX_SHIFT      = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sample_tick,
  input  logic [7:0]         voice_enable,
  input  logic               calc_ready,
  input  logic signed [15:0] calc_out1,
  input  logic signed [15:0] calc_out2,
  input  logic signed [15:0] calc_out3,
  input  logic signed [15:0] calc_out4,
  input  logic signed [15:0] calc_out5,
  input  logic signed [15:0] calc_out6,
  input  logic signed [15:0] calc_out7,
  input  logic signed [15:0] calc_out8,
  input  logic               clear_flags,
  output logic               calc_start,
  output logic signed [15:0] mix_out,
  output logic               mix_valid,
  output logic               busy,
  output logic               overrun,
  output logic               timeout
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_ACC, S_OUT} state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t             state_q, state_d;
  logic [7:0][15:0]   voice_q, voice_d;
  logic [7:0]         en_q, en_d;
  logic [2:0]         idx_q, idx_d;
  logic [15:0]        cnt_q, cnt_d;
  logic signed [18:0] acc_q, acc_d;
  logic signed [15:0] mix_q, mix_d;
  logic               ovr_q, ovr_d;
  logic               to_q, to_d;

  logic signed [18:0] addend;
  logic signed [18:0] acc_sum;
  logic signed [18:0] shifted;
  logic signed [15:0] sat;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      voice_q <= '0;
      en_q    <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      mix_q   <= '0;
      ovr_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      voice_q <= voice_d;
      en_q    <= en_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mix_q   <= mix_d;
      ovr_q   <= ovr_d;
      to_q    <= to_d;
    end
  end

  // The last voice is folded in on the same edge that registers the result.
  always_comb begin
    addend  = en_q[idx_q] ? {{3{voice_q[idx_q][15]}}, voice_q[idx_q]} : '0;
    acc_sum = acc_q + addend;
    shifted = acc_sum >>> MIX_SHIFT;
    if (shifted > 19'sd32767)
      sat = 16'sh7FFF;
    else if (shifted < -19'sd32768)
      sat = 16'sh8000;
    else
      sat = shifted[15:0];
  end

  always_comb begin
    state_d    = state_q;
    voice_d    = voice_q;
    en_d       = en_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    mix_d      = mix_q;
    ovr_d      = ovr_q;
    to_d       = to_q;
    calc_start = 1'b0;
    mix_valid  = 1'b0;

    if (clear_flags) begin
      ovr_d = 1'b0;
      to_d  = 1'b0;
    end
    if (sample_tick && (state_q != S_IDLE))
      ovr_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (sample_tick)
          state_d = S_START;
      end
      S_START: begin
        calc_start = 1'b1;
        cnt_d      = '0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (calc_ready) begin
          voice_d = {calc_out8, calc_out7, calc_out6, calc_out5,
                     calc_out4, calc_out3, calc_out2, calc_out1};
          en_d    = voice_enable;
          acc_d   = '0;
          idx_d   = '0;
          state_d = S_ACC;
        end else if (cnt_q == TO_LAST) begin
          to_d    = 1'b1;
          mix_d   = '0;
          state_d = S_OUT;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_ACC: begin
        acc_d = acc_sum;
        idx_d = idx_q + 3'd1;
        if (idx_q == 3'd7) begin
          mix_d   = sat;
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        mix_valid = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy    = (state_q != S_IDLE);
  assign mix_out = mix_q;
  assign overrun = ovr_q;
  assign timeout = to_q;

endmodule
